// File: rtl/mips_dmem_bridge.sv
// mips_dmem_bridge
// Data-memory bridge between the MIPS datapath and a variable-latency req/ack memory bus.
// Each load/store becomes one bus transaction. The core is stalled until the access
// completes. Load data comes back through a registered path. Misaligned, bus-error and
// timed-out accesses are reported with a one-cycle error pulse.
//
// Ports:
//   i_clk, i_rst            clock (rising edge), synchronous active-high reset
//   i_mem_read/i_mem_write  load/store strobes from the controller (write wins if both)
//   i_addr, i_wdata         byte address (ALU result) and store data
//   o_rdata                 registered load data
//   o_stall                 core holds PC/registers while high
//   o_err_valid, o_err_code error pulse; 01 misaligned, 10 bus error, 11 timeout
//   o_bus_req/we/addr/wdata bus request side, latched for the whole transaction
//   i_bus_ack, i_bus_rdata  completion and read data
//   i_bus_err               slave error, treated as completion
module mips_dmem_bridge #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_mem_read,
    input  logic                  i_mem_write,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  o_stall,
    output logic                  o_err_valid,
    output logic [1:0]            o_err_code,
    output logic                  o_bus_req,
    output logic                  o_bus_we,
    output logic [ADDR_WIDTH-1:0] o_bus_addr,
    output logic [DATA_WIDTH-1:0] o_bus_wdata,
    input  logic                  i_bus_ack,
    input  logic [DATA_WIDTH-1:0] i_bus_rdata,
    input  logic                  i_bus_err
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } state_t;

    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_BUS      = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    // Counter value seen in the last permitted BUSY cycle (it starts at 0 in the first).
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t                r_state;
    state_t                w_state_next;
    logic [15:0]           r_cnt;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_bus_req;
    logic                  r_bus_we;
    logic [ADDR_WIDTH-1:0] r_bus_addr;
    logic [DATA_WIDTH-1:0] r_bus_wdata;
    logic                  r_err_pend;
    logic [1:0]            r_err_code;

    logic w_access;
    logic w_aligned;
    logic w_start;
    logic w_misalign;
    logic w_timeout;

    always_comb begin
        w_access   = i_mem_read | i_mem_write;
        w_aligned  = (i_addr[1:0] == 2'b00);
        w_start    = (r_state == StIdle) && w_access && w_aligned;
        w_misalign = (r_state == StIdle) && w_access && !w_aligned;
        w_timeout  = (r_cnt == CNT_LAST);
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (w_start) begin
                    w_state_next = StBusy;
                end
            end
            StBusy: begin
                if (i_bus_ack || i_bus_err || w_timeout) begin
                    w_state_next = StDone;
                end
            end
            // The core advances on this edge; the next instruction is sampled in IDLE.
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_cnt       <= 16'd0;
            r_rdata     <= '0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_err_pend  <= 1'b0;
            r_err_code  <= 2'b00;
        end else begin
            r_state    <= w_state_next;
            // bus_req is high exactly while the FSM sits in BUSY.
            r_bus_req  <= (w_state_next == StBusy);
            r_err_pend <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_start) begin
                        r_bus_we    <= i_mem_write;
                        r_bus_addr  <= {i_addr[ADDR_WIDTH-1:2], 2'b00};
                        r_bus_wdata <= i_wdata;
                        r_cnt       <= 16'd0;
                    end else if (w_misalign) begin
                        r_rdata <= '0;
                    end
                end
                StBusy: begin
                    r_cnt <= r_cnt + 16'd1;
                    if (i_bus_ack) begin
                        if (!r_bus_we) begin
                            r_rdata <= i_bus_rdata;
                        end
                    end else if (i_bus_err) begin
                        r_rdata    <= '0;
                        r_err_pend <= 1'b1;
                        r_err_code <= ERR_BUS;
                    end else if (w_timeout) begin
                        r_rdata    <= '0;
                        r_err_pend <= 1'b1;
                        r_err_code <= ERR_TIMEOUT;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        o_rdata     = r_rdata;
        o_stall     = w_start || (r_state == StBusy);
        // Misaligned errors are flagged in the same cycle; bus errors in the DONE cycle.
        o_err_valid = w_misalign || ((r_state == StDone) && r_err_pend);
        o_err_code  = w_misalign ? ERR_MISALIGN : r_err_code;
        o_bus_req   = r_bus_req;
        o_bus_we    = r_bus_we;
        o_bus_addr  = r_bus_addr;
        o_bus_wdata = r_bus_wdata;
    end

endmodule
